// File: rtl/id_ex_if.sv
// Bundle between the ID/EX stage and its neighbours: decode inputs, forwarding taps and
// ALU/EX-MEM outputs. Valid/ready: a beat transfers on a rising edge where valid && ready.
interface id_ex_if #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 4,
    parameter int IMM_WIDTH      = 16
);
    logic                      flush;
    logic                      idValid;
    logic                      idReady;
    logic [REG_ADDR_WIDTH-1:0] idRsAddr;
    logic [REG_ADDR_WIDTH-1:0] idRtAddr;
    logic [REG_ADDR_WIDTH-1:0] idDestAddr;
    logic [DATA_WIDTH-1:0]     idRsData;
    logic [DATA_WIDTH-1:0]     idRtData;
    logic [IMM_WIDTH-1:0]      idImm;
    logic [REG_ADDR_WIDTH-1:0] idShamt;
    logic [OP_WIDTH-1:0]       idAluOp;
    logic                      idUseImm;
    logic                      idZeroExt;
    logic                      idUseShamt;
    logic                      idRegWrite;
    logic                      idMemRead;
    logic                      memFwdValid;
    logic                      memFwdIsLoad;
    logic [REG_ADDR_WIDTH-1:0] memFwdAddr;
    logic [DATA_WIDTH-1:0]     memFwdData;
    logic                      wbFwdValid;
    logic [REG_ADDR_WIDTH-1:0] wbFwdAddr;
    logic [DATA_WIDTH-1:0]     wbFwdData;
    logic                      exValid;
    logic                      exReady;
    logic [DATA_WIDTH-1:0]     aluInputA;
    logic [DATA_WIDTH-1:0]     aluInputB;
    logic [OP_WIDTH-1:0]       aluOperation;
    logic [DATA_WIDTH-1:0]     exStoreData;
    logic [REG_ADDR_WIDTH-1:0] exDestAddr;
    logic                      exRegWrite;
    logic                      exMemRead;

    modport slave (
        input  flush, idValid, idRsAddr, idRtAddr, idDestAddr, idRsData, idRtData,
               idImm, idShamt, idAluOp, idUseImm, idZeroExt, idUseShamt, idRegWrite, idMemRead,
               memFwdValid, memFwdIsLoad, memFwdAddr, memFwdData,
               wbFwdValid, wbFwdAddr, wbFwdData, exReady,
        output idReady, exValid, aluInputA, aluInputB, aluOperation,
               exStoreData, exDestAddr, exRegWrite, exMemRead
    );

    modport master (
        output flush, idValid, idRsAddr, idRtAddr, idDestAddr, idRsData, idRtData,
               idImm, idShamt, idAluOp, idUseImm, idZeroExt, idUseShamt, idRegWrite, idMemRead,
               memFwdValid, memFwdIsLoad, memFwdAddr, memFwdData,
               wbFwdValid, wbFwdAddr, wbFwdData, exReady,
        input  idReady, exValid, aluInputA, aluInputB, aluOperation,
               exStoreData, exDestAddr, exRegWrite, exMemRead
    );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use stall and branch flush.
// Define ID_EX_FORWARD_EN for forwarding; otherwise the stage stalls on any in-flight match.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int OP_WIDTH       = 4,
    parameter int IMM_WIDTH      = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    id_ex_if.slave     bus,
    output logic [1:0] state
);
    localparam logic [1:0] ST_EMPTY  = 2'd0;
    localparam logic [1:0] ST_READY  = 2'd1;
    localparam logic [1:0] ST_HAZARD = 2'd2;

    logic                      full;
    logic [REG_ADDR_WIDTH-1:0] rs_addr, rt_addr, dest_addr, shamt;
    logic [DATA_WIDTH-1:0]     rs_data, rt_data;
    logic [IMM_WIDTH-1:0]      imm;
    logic [OP_WIDTH-1:0]       alu_op;
    logic                      use_imm, zero_ext, use_shamt, reg_write, mem_read;

    logic                  mem_rs, mem_rt, wb_rs, wb_rt;
    logic [DATA_WIDTH-1:0] fwd_rs, fwd_rt;
    logic                  hazard, ex_valid, id_ready, load, drain;

    // Register 0 is hard-wired zero and never forwarded.
    assign mem_rs = (rs_addr != '0) && bus.memFwdValid && (bus.memFwdAddr == rs_addr);
    assign mem_rt = (rt_addr != '0) && bus.memFwdValid && (bus.memFwdAddr == rt_addr);
    assign wb_rs  = (rs_addr != '0) && bus.wbFwdValid  && (bus.wbFwdAddr  == rs_addr);
    assign wb_rt  = (rt_addr != '0) && bus.wbFwdValid  && (bus.wbFwdAddr  == rt_addr);

`ifdef ID_EX_FORWARD_EN
    assign fwd_rs = mem_rs ? bus.memFwdData : (wb_rs ? bus.wbFwdData : rs_data);
    assign fwd_rt = mem_rt ? bus.memFwdData : (wb_rt ? bus.wbFwdData : rt_data);
    // A load in MEM has no data yet; wait until it reaches WB.
    assign hazard = full && bus.memFwdIsLoad && (mem_rs || mem_rt);
`else
    logic fwd_unused;
    assign fwd_unused = ^{bus.memFwdData, bus.wbFwdData, bus.memFwdIsLoad};
    assign fwd_rs     = rs_data;
    assign fwd_rt     = rt_data;
    assign hazard     = full && (mem_rs || mem_rt || wb_rs || wb_rt);
`endif

    assign ex_valid = full && !hazard;
    assign drain    = ex_valid && bus.exReady;
    assign id_ready = !full || drain;
    assign load     = bus.idValid && id_ready && !bus.flush;

    assign bus.exValid = ex_valid;
    assign bus.idReady = id_ready;

    always_comb begin
        state = ST_EMPTY;
        if (full) state = hazard ? ST_HAZARD : ST_READY;
    end

    always_comb begin
        bus.aluInputA    = '0;
        bus.aluInputB    = '0;
        bus.aluOperation = '0;
        bus.exStoreData  = '0;
        bus.exDestAddr   = '0;
        bus.exRegWrite   = 1'b0;
        bus.exMemRead    = 1'b0;
        if (full) begin
            bus.aluInputA = use_shamt ? {{(DATA_WIDTH-REG_ADDR_WIDTH){1'b0}}, shamt} : fwd_rs;
            if (!use_imm)
                bus.aluInputB = fwd_rt;
            else if (zero_ext)
                bus.aluInputB = {{(DATA_WIDTH-IMM_WIDTH){1'b0}}, imm};
            else
                bus.aluInputB = {{(DATA_WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm};
            bus.aluOperation = alu_op;
            bus.exStoreData  = fwd_rt;
            bus.exDestAddr   = dest_addr;
            bus.exRegWrite   = reg_write;
            bus.exMemRead    = mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            full      <= 1'b0;
            rs_addr   <= '0;
            rt_addr   <= '0;
            dest_addr <= '0;
            shamt     <= '0;
            rs_data   <= '0;
            rt_data   <= '0;
            imm       <= '0;
            alu_op    <= '0;
            use_imm   <= 1'b0;
            zero_ext  <= 1'b0;
            use_shamt <= 1'b0;
            reg_write <= 1'b0;
            mem_read  <= 1'b0;
        end else if (bus.flush) begin
            full <= 1'b0;
        end else if (load) begin
            full      <= 1'b1;
            rs_addr   <= bus.idRsAddr;
            rt_addr   <= bus.idRtAddr;
            dest_addr <= bus.idDestAddr;
            shamt     <= bus.idShamt;
            rs_data   <= bus.idRsData;
            rt_data   <= bus.idRtData;
            imm       <= bus.idImm;
            alu_op    <= bus.idAluOp;
            use_imm   <= bus.idUseImm;
            zero_ext  <= bus.idZeroExt;
            use_shamt <= bus.idUseShamt;
            reg_write <= bus.idRegWrite;
            mem_read  <= bus.idMemRead;
        end else if (drain) begin
            full <= 1'b0;
        end
`ifdef ID_EX_FORWARD_EN
        // Capture forwarded values while held so a producer retiring mid-stall is not lost.
        else if (full) begin
            rs_data <= fwd_rs;
            rt_data <= fwd_rt;
        end
`endif
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage; expectations adapt to whether ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;
`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    localparam logic [3:0] ALU_ADDU = 4'h2;
    localparam logic [3:0] ALU_SUBU = 4'h6;
    localparam logic [3:0] ALU_OR   = 4'h4;
    localparam logic [3:0] ALU_SLL  = 4'h8;

    typedef struct packed {
        logic [4:0]  rs_a, rt_a, dest, shamt;
        logic [31:0] rs_d, rt_d;
        logic [15:0] imm;
        logic [3:0]  op;
        logic        use_imm, zero_ext, use_shamt, reg_write, mem_read;
        logic        mv, ml;
        logic [4:0]  ma;
        logic [31:0] md;
        logic        wv;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        exp_hz;
        logic [31:0] exp_a, exp_b, exp_st;
    } vec_t;

    typedef struct packed {
        logic [31:0] a, b, st;
        logic [3:0]  op;
        logic [4:0]  dest;
        logic        rw, mr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] state;
    int         checks = 0;
    int         errors = 0;
    exp_t       exp_q[$];
    vec_t       vecs[9];

    id_ex_if bus ();
    id_ex_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus), .state(state));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every accepted downstream beat must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && bus.exValid === 1'b1 && bus.exReady === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got beat A=%h expected none", bus.aluInputA);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_a", bus.aluInputA, e.a);
                chk("sb_b", bus.aluInputB, e.b);
                chk("sb_store", bus.exStoreData, e.st);
                chk("sb_op", {28'b0, bus.aluOperation}, {28'b0, e.op});
                chk("sb_dest", {27'b0, bus.exDestAddr}, {27'b0, e.dest});
                chk("sb_rw", {31'b0, bus.exRegWrite}, {31'b0, e.rw});
                chk("sb_mr", {31'b0, bus.exMemRead}, {31'b0, e.mr});
            end
        end
    end

    function automatic vec_t base(input logic [3:0] op, input logic [4:0] rs_a, input logic [31:0] rs_d,
                                  input logic [4:0] rt_a, input logic [31:0] rt_d, input logic [4:0] dest);
        vec_t v;
        v = '0;
        v.op = op; v.rs_a = rs_a; v.rs_d = rs_d; v.rt_a = rt_a; v.rt_d = rt_d;
        v.dest = dest; v.reg_write = 1'b1;
        v.exp_a = rs_d; v.exp_b = rt_d; v.exp_st = rt_d;
        return v;
    endfunction

    task automatic drive_instr(input vec_t v);
        bus.idRsAddr = v.rs_a;   bus.idRtAddr = v.rt_a;   bus.idDestAddr = v.dest;
        bus.idRsData = v.rs_d;   bus.idRtData = v.rt_d;   bus.idImm = v.imm;
        bus.idShamt = v.shamt;   bus.idAluOp = v.op;      bus.idUseImm = v.use_imm;
        bus.idZeroExt = v.zero_ext; bus.idUseShamt = v.use_shamt;
        bus.idRegWrite = v.reg_write; bus.idMemRead = v.mem_read;
        bus.idValid = 1'b1;
    endtask

    task automatic set_fwd(input logic mv, input logic ml, input logic [4:0] ma, input logic [31:0] md,
                           input logic wv, input logic [4:0] wa, input logic [31:0] wd);
        bus.memFwdValid = mv; bus.memFwdIsLoad = ml; bus.memFwdAddr = ma; bus.memFwdData = md;
        bus.wbFwdValid = wv; bus.wbFwdAddr = wa; bus.wbFwdData = wd;
    endtask

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.a = v.exp_a; e.b = v.exp_b; e.st = v.exp_st; e.op = v.op;
        e.dest = v.dest; e.rw = v.reg_write; e.mr = v.mem_read;
        exp_q.push_back(e);
    endtask

    // Called at posedge+1 with the stage empty and exReady low.
    task automatic run_vec(input int idx, input vec_t v);
        drive_instr(v);
        set_fwd(v.mv, v.ml, v.ma, v.md, v.wv, v.wa, v.wd);
        @(posedge clk); #1;
        bus.idValid = 1'b0;
        #1;
        chk($sformatf("v%0d_exvalid", idx), {31'b0, bus.exValid}, {31'b0, !v.exp_hz});
        chk($sformatf("v%0d_idready", idx), {31'b0, bus.idReady}, 32'd0);
        chk($sformatf("v%0d_state", idx), {30'b0, state}, v.exp_hz ? 32'd2 : 32'd1);
        chk($sformatf("v%0d_a", idx), bus.aluInputA, v.exp_a);
        chk($sformatf("v%0d_b", idx), bus.aluInputB, v.exp_b);
        chk($sformatf("v%0d_store", idx), bus.exStoreData, v.exp_st);
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk($sformatf("v%0d_a_held", idx), bus.aluInputA, v.exp_a);
        chk($sformatf("v%0d_b_held", idx), bus.aluInputB, v.exp_b);
        push_exp(v);
        bus.exReady = 1'b1;
        @(posedge clk); #1;
        chk($sformatf("v%0d_drained", idx), {31'b0, bus.exValid}, 32'd0);
        chk($sformatf("v%0d_idready_empty", idx), {31'b0, bus.idReady}, 32'd1);
        bus.exReady = 1'b0;
    endtask

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        vec_t v;
        vec_t i1;
        vec_t i2;
        bus.flush = 1'b0; bus.exReady = 1'b0;
        drive_instr('0);
        bus.idValid = 1'b0;
        set_fwd(0, 0, 0, 0, 0, 0, 0);

        vecs[0] = base(ALU_ADDU, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        vecs[1] = base(ALU_ADDU, 5'd3, 32'h33, 5'd5, 32'h55, 5'd6);
        vecs[1].mv = 1; vecs[1].ma = 5'd3; vecs[1].md = 32'hAA;
        vecs[1].wv = 1; vecs[1].wa = 5'd3; vecs[1].wd = 32'hBB;
        vecs[1].exp_hz = !FWD; vecs[1].exp_a = FWD ? 32'hAA : 32'h33;
        vecs[2] = vecs[1];
        vecs[2].mv = 0; vecs[2].exp_a = FWD ? 32'hBB : 32'h33;
        vecs[3] = base(ALU_ADDU, 5'd0, 32'h77, 5'd5, 32'h55, 5'd6);
        vecs[3].mv = 1; vecs[3].ma = 5'd0; vecs[3].md = 32'h11;
        vecs[4] = base(ALU_OR, 5'd1, 32'd5, 5'd6, 32'h66, 5'd6);
        vecs[4].imm = 16'hFFF0; vecs[4].use_imm = 1; vecs[4].exp_b = 32'hFFFF_FFF0;
        vecs[5] = vecs[4];
        vecs[5].zero_ext = 1; vecs[5].exp_b = 32'h0000_FFF0;
        vecs[6] = base(ALU_SLL, 5'd7, 32'h70, 5'd8, 32'h80, 5'd9);
        vecs[6].shamt = 5'd3; vecs[6].use_shamt = 1; vecs[6].exp_a = 32'd3;
        vecs[7] = base(ALU_SUBU, 5'd1, 32'd5, 5'd8, 32'h88, 5'd10);
        vecs[7].wv = 1; vecs[7].wa = 5'd8; vecs[7].wd = 32'hCAFE; vecs[7].mem_read = 1;
        vecs[7].exp_hz = !FWD;
        vecs[7].exp_b = FWD ? 32'hCAFE : 32'h88; vecs[7].exp_st = vecs[7].exp_b;
        vecs[8] = base(ALU_ADDU, 5'd9, 32'h90, 5'd9, 32'h91, 5'd11);
        vecs[8].mv = 1; vecs[8].ma = 5'd9; vecs[8].md = 32'hDEAD;
        vecs[8].exp_hz = !FWD; vecs[8].exp_a = FWD ? 32'hDEAD : 32'h90;
        vecs[8].exp_b = FWD ? 32'hDEAD : 32'h91; vecs[8].exp_st = vecs[8].exp_b;

        // Reset
        @(posedge clk); @(posedge clk); #1;
        chk("rst_exvalid", {31'b0, bus.exValid}, 32'd0);
        chk("rst_a", bus.aluInputA, 32'd0);
        chk("rst_b", bus.aluInputB, 32'd0);
        chk("rst_idready", {31'b0, bus.idReady}, 32'd1);
        chk("rst_state", {30'b0, state}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Load-use: rt produced by a load in MEM, then visible from WB.
        v = base(ALU_ADDU, 5'd1, 32'd1, 5'd4, 32'h44, 5'd12);
        drive_instr(v);
        set_fwd(1, 1, 5'd4, 32'h99, 0, 0, 0);
        @(posedge clk); #1;
        bus.idValid = 1'b0;
        #1;
        chk("lu_exvalid_stall", {31'b0, bus.exValid}, 32'd0);
        chk("lu_idready_stall", {31'b0, bus.idReady}, 32'd0);
        chk("lu_state_hazard", {30'b0, state}, 32'd2);
        set_fwd(0, 0, 0, 0, 1, 5'd4, 32'h1234);
        #1;
        chk("lu_exvalid_wb", {31'b0, bus.exValid}, {31'b0, FWD});
        @(posedge clk); #1;
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        #1;
        v.exp_b = FWD ? 32'h1234 : 32'h44; v.exp_st = v.exp_b;
        chk("lu_exvalid_clear", {31'b0, bus.exValid}, 32'd1);
        chk("lu_b", bus.aluInputB, v.exp_b);
        push_exp(v);
        bus.exReady = 1'b1;
        @(posedge clk); #1;
        bus.exReady = 1'b0;

        // Stall with WB refresh, then flush with a competing input.
        v = base(ALU_ADDU, 5'd9, 32'h90, 5'd10, 32'hA0, 5'd13);
        drive_instr(v);
        @(posedge clk); #1;
        bus.idValid = 1'b0;
        set_fwd(0, 0, 0, 0, 1, 5'd10, 32'hBEEF);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("st_idready", {31'b0, bus.idReady}, 32'd0);
            chk("st_a", bus.aluInputA, 32'h90);
            chk("st_b", bus.aluInputB, FWD ? 32'hBEEF : 32'hA0);
            chk("st_exvalid", {31'b0, bus.exValid}, {31'b0, FWD});
            @(posedge clk); #1;
        end
        set_fwd(0, 0, 0, 0, 0, 0, 0);
        #1;
        chk("st_b_refreshed", bus.aluInputB, FWD ? 32'hBEEF : 32'hA0);
        chk("st_exvalid_free", {31'b0, bus.exValid}, 32'd1);
        drive_instr(base(ALU_SUBU, 5'd11, 32'hB0, 5'd12, 32'hC0, 5'd14));
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        bus.idValid = 1'b0;
        #1;
        chk("fl_exvalid", {31'b0, bus.exValid}, 32'd0);
        chk("fl_a", bus.aluInputA, 32'd0);
        chk("fl_idready", {31'b0, bus.idReady}, 32'd1);
        chk("fl_state", {30'b0, state}, 32'd0);
        @(posedge clk); #1;
        chk("fl_not_captured", {31'b0, bus.exValid}, 32'd0);

        // Back-to-back: load and drain on the same edge.
        i1 = base(ALU_ADDU, 5'd12, 32'hC0, 5'd13, 32'hD0, 5'd14);
        i2 = base(ALU_SUBU, 5'd15, 32'hE0, 5'd16, 32'hF0, 5'd17);
        i2.mem_read = 1'b1;
        bus.exReady = 1'b1;
        drive_instr(i1);
        @(posedge clk); #1;
        push_exp(i1);
        drive_instr(i2);
        #1;
        chk("b2b_idready", {31'b0, bus.idReady}, 32'd1);
        @(posedge clk); #1;
        push_exp(i2);
        bus.idValid = 1'b0;
        #1;
        chk("b2b_second_a", bus.aluInputA, 32'hE0);
        @(posedge clk); #1;
        chk("b2b_empty", {31'b0, bus.exValid}, 32'd0);
        bus.exReady = 1'b0;

        @(posedge clk); #1;
        chk("sb_queue_empty", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
